// File: rtl/bcd_stopwatch_2dig.sv
// Two-digit BCD stopwatch: debounced start/stop and clear buttons, up/down
// counting at a prescaled tick rate, with a wrap pulse on 99<->00 transitions.
module bcd_stopwatch_2dig #(
    parameter int DEB_DIV  = 16000,
    parameter int TICK_DIV = 16000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       dir,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic       running,
    output logic       tc
);
    localparam int DEB_W  = (DEB_DIV  > 1) ? $clog2(DEB_DIV)  : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    // Bit 0 = start/stop, bit 1 = clear, bit 2 = direction
    logic [2:0] raw_in;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;

    assign raw_in = {dir, btn_clr, btn_ss};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    logic [DEB_W-1:0] deb_cnt_reg;
    logic             deb_en;
    logic             sample_valid_reg;

    assign deb_en = (deb_cnt_reg == DEB_W'(DEB_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_reg      <= '0;
            sample_valid_reg <= 1'b0;
        end else if (deb_en) begin
            deb_cnt_reg      <= '0;
            sample_valid_reg <= 1'b1;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
    end

    logic [1:0] btn_pulse;

    // A button must be seen confirmed-released before its next press may pulse,
    // so a button held through reset stays silent until pressed again.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic sample_reg;
            logic level_reg;
            logic level_prev_reg;
            logic arm_reg;
            logic pulse_reg;
            logic agree;

            assign agree = sample_valid_reg && (sync2_reg[gi] == sample_reg);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sample_reg     <= 1'b0;
                    level_reg      <= 1'b0;
                    level_prev_reg <= 1'b0;
                    arm_reg        <= 1'b0;
                    pulse_reg      <= 1'b0;
                end else begin
                    level_prev_reg <= level_reg;
                    pulse_reg      <= level_reg & ~level_prev_reg & arm_reg;
                    if (deb_en) begin
                        sample_reg <= sync2_reg[gi];
                        if (agree) begin
                            level_reg <= sync2_reg[gi];
                            if (!sync2_reg[gi]) begin
                                arm_reg <= 1'b1;
                            end
                        end
                    end
                end
            end

            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

    logic ss_p;
    logic clr_p;
    logic dir_s;

    assign ss_p  = btn_pulse[0];
    assign clr_p = btn_pulse[1];
    assign dir_s = sync2_reg[2];

    logic [1:0]        state_reg, state_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [3:0]        d0_reg, d0_next;
    logic [3:0]        d1_reg, d1_next;
    logic              tc_reg, tc_next;
    logic              tick;

    assign tick = (state_reg == RUN) && (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        d0_next       = d0_reg;
        d1_next       = d1_reg;
        tc_next       = 1'b0;
        if (clr_p) begin
            state_next    = IDLE;
            tick_cnt_next = '0;
            d0_next       = 4'd0;
            d1_next       = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tick_cnt_next = '0;
                    if (ss_p) state_next = RUN;
                end
                RUN: begin
                    tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);
                    if (ss_p) state_next = PAUSE;
                end
                PAUSE: begin
                    if (ss_p) state_next = RUN;
                end
                default: begin
                    state_next    = IDLE;
                    tick_cnt_next = '0;
                end
            endcase

            // Digits advance on the tick even if a stop press lands in the same cycle
            if (tick) begin
                if (!dir_s) begin
                    if (d0_reg >= 4'd9) begin
                        d0_next = 4'd0;
                        if (d1_reg >= 4'd9) begin
                            d1_next = 4'd0;
                            tc_next = 1'b1;
                        end else begin
                            d1_next = d1_reg + 4'd1;
                        end
                    end else begin
                        d0_next = d0_reg + 4'd1;
                    end
                end else begin
                    if (d0_reg == 4'd0 || d0_reg > 4'd9) begin
                        d0_next = 4'd9;
                        if (d1_reg == 4'd0 || d1_reg > 4'd9) begin
                            d1_next = 4'd9;
                            tc_next = 1'b1;
                        end else begin
                            d1_next = d1_reg - 4'd1;
                        end
                    end else begin
                        d0_next = d0_reg - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            d0_reg       <= 4'd0;
            d1_reg       <= 4'd0;
            tc_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            d0_reg       <= d0_next;
            d1_reg       <= d1_next;
            tc_reg       <= tc_next;
        end
    end

    assign d0      = d0_reg;
    assign d1      = d1_reg;
    assign running = (state_reg == RUN);
    assign tc      = tc_reg;

endmodule

// File: tb/tb_bcd_stopwatch_2dig.sv
// Scoreboard bench for bcd_stopwatch_2dig: a behavioural model queues the
// expected display each cycle and a monitor compares it with the DUT.
module tb_bcd_stopwatch_2dig;
    localparam int DEB_DIV  = 4;
    localparam int TICK_DIV = 10;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       running;
    logic       tc;

    bcd_stopwatch_2dig #(
        .DEB_DIV (DEB_DIV),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_ss (btn_ss),
        .btn_clr(btn_clr),
        .dir    (dir),
        .d0     (d0),
        .d1     (d1),
        .running(running),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        bit run;
        bit wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: stopwatch value kept as an integer 0..99
    int       m_value, m_state, m_presc, m_k;
    bit       m_tc;
    bit [2:0] m_s1, m_s2;
    bit       m_have;
    bit [1:0] m_last, m_level, m_armed;
    int       m_due [2];
    bit       model_started = 1'b0;

    task automatic model_step();
        bit   fire [2];
        bit   tick;
        bit   deb_en;
        bit   up;
        exp_t e;
        if (rst) begin
            m_value = 0; m_state = M_IDLE; m_presc = 0; m_tc = 0; m_k = 0;
            m_s1 = '0; m_s2 = '0; m_have = 0;
            m_last = '0; m_level = '0; m_armed = '0;
            m_due[0] = 0; m_due[1] = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                fire[b] = 1'b0;
                if (m_due[b] > 0) begin
                    m_due[b]--;
                    fire[b] = (m_due[b] == 0);
                end
            end
            tick = (m_state == M_RUN) && (m_presc == TICK_DIV - 1);
            up   = !m_s2[2];
            m_tc = 1'b0;
            if (fire[1]) begin
                m_state = M_IDLE; m_presc = 0; m_value = 0;
            end else begin
                if (m_state == M_RUN) m_presc = (m_presc + 1) % TICK_DIV;
                if (tick) begin
                    if (up) begin
                        m_tc = (m_value == 99);
                        m_value = (m_value + 1) % 100;
                    end else begin
                        m_tc = (m_value == 0);
                        m_value = (m_value + 99) % 100;
                    end
                end
                if (fire[0]) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
            end
            // A press is seen by the FSM two cycles after its level is confirmed
            deb_en = ((m_k % DEB_DIV) == DEB_DIV - 1);
            m_k++;
            if (deb_en) begin
                for (int b = 0; b < 2; b++) begin
                    if (m_have && m_s2[b] == m_last[b]) begin
                        if (m_s2[b] && !m_level[b] && m_armed[b]) m_due[b] = 2;
                        if (!m_s2[b]) m_armed[b] = 1'b1;
                        m_level[b] = m_s2[b];
                    end
                    m_last[b] = m_s2[b];
                end
                m_have = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = {dir, btn_clr, btn_ss};
        end
        e.value = m_value;
        e.run   = (m_state == M_RUN);
        e.wrap  = m_tc;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            model_started = 1'b1;
        end
    end

    int run_rises = 0;
    int tc_seen   = 0;
    bit prev_running = 1'b0;

    task automatic monitor_step();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: no expected entry queued", $time);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (d1 !== 4'(e.value / 10) || d0 !== 4'(e.value % 10) ||
            running !== e.run || tc !== e.wrap) begin
            errors++;
            $display("FAIL outputs at %0t: got d1d0=%0d%0d running=%0b tc=%0b, required d1d0=%0d%0d running=%0b tc=%0b",
                     $time, d1, d0, running, tc, e.value / 10, e.value % 10, e.run, e.wrap);
        end
        checks++;
        if (!(d0 <= 4'd9 && d1 <= 4'd9)) begin
            errors++;
            $display("FAIL digit_range at %0t: got d1=%0d d0=%0d, required both <= 9", $time, d1, d0);
        end
        if (running === 1'b1 && !prev_running) run_rises++;
        if (tc === 1'b1) tc_seen++;
        prev_running = (running === 1'b1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_started) monitor_step();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 = start/stop, 1 = clear, 2 = both together
    task automatic set_btn(input int which, input logic v);
        if (which == 0 || which == 2) btn_ss = v;
        if (which == 1 || which == 2) btn_clr = v;
    endtask

    task automatic press(input int which, input int glitches, input int hold);
        $display("[%0t] press btn=%0d glitches=%0d hold=%0d", $time, which, glitches, hold);
        for (int g = 0; g < glitches; g++) begin
            set_btn(which, 1'b1); step(1);
            set_btn(which, 1'b0); step($urandom_range(5, 7));
        end
        set_btn(which, 1'b1); step(hold);
        for (int g = 0; g < glitches; g++) begin
            set_btn(which, 1'b0); step(1);
            set_btn(which, 1'b1); step($urandom_range(5, 7));
        end
        set_btn(which, 1'b0); step(12);
    endtask

    task automatic wait_value(input int target, input int limit);
        int n = 0;
        while (m_value != target && n < limit) begin
            step(1);
            n++;
        end
        checks++;
        if (m_value != target) begin
            errors++;
            $display("FAIL wait_value: reached %0d, required %0d within %0d cycles", m_value, target, limit);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        int r0;
        int t0;
        $display("[%0t] reset", $time);
        rst = 1'b1; step(3); rst = 1'b0; step(4);

        // Bouncy start press: one start, digits step every TICK_DIV cycles
        r0 = run_rises;
        press(0, 5, 40);
        step(20);
        check_int("single_start_rise", run_rises - r0, 1);
        check_int("running_after_start", int'(running), 1);

        // Up wrap 99 -> 00
        t0 = tc_seen;
        $display("[%0t] count up to wrap", $time);
        wait_value(98, 1500);
        step(40);
        // Down wrap 00 -> 99 starting from 01
        press(1, 0, 15);
        dir = 1'b0;
        press(0, 0, 15);
        wait_value(1, 200);
        $display("[%0t] switch to down count", $time);
        dir = 1'b1;
        step(40);
        check_int("wrap_pulses", tc_seen - t0, 2);

        // Pause mid-prescaler, hold 50 cycles, resume
        press(0, 2, 15);
        check_int("paused", int'(running), 0);
        step(50);
        press(0, 2, 15);
        step(30);

        // Clear and start/stop confirmed together: clear wins
        press(1, 0, 15);
        dir = 1'b0;
        press(0, 0, 15);
        wait_value(37, 600);
        press(2, 0, 15);
        step(10);
        check_int("clr_ss_value", int'({d1, d0}), 0);
        check_int("clr_ss_running", int'(running), 0);

        // Reset during RUN with start/stop held through reset release
        $display("[%0t] hold start/stop and reset mid-count", $time);
        btn_ss = 1'b1;
        wait_value(45, 600);
        rst = 1'b1; step(1); rst = 1'b0;
        r0 = run_rises;
        step(60);
        check_int("no_start_after_reset", run_rises - r0, 0);
        check_int("reset_value", int'({d1, d0}), 0);
        btn_ss = 1'b0;
        step(15);
        press(0, 1, 15);
        step(5);
        check_int("restart_after_release", run_rises - r0, 1);

        // Randomised operation
        for (int i = 0; i < 40; i++) begin
            int a;
            a = $urandom_range(0, 11);
            if (a <= 3) begin
                press(0, $urandom_range(0, 3), $urandom_range(12, 30));
            end else if (a == 4) begin
                press(1, $urandom_range(0, 2), $urandom_range(12, 20));
            end else if (a == 5) begin
                dir = ~dir;
                $display("[%0t] dir=%0b", $time, dir);
            end else if (a == 6) begin
                $display("[%0t] reset pulse", $time);
                rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0;
            end else if (a == 7) begin
                $display("[%0t] reset during debounce", $time);
                btn_ss = 1'b1; step($urandom_range(2, 8));
                rst = 1'b1; step(1); rst = 1'b0;
                step($urandom_range(0, 6)); btn_ss = 1'b0; step(12);
            end else begin
                $display("[%0t] idle", $time);
                step($urandom_range(1, 60));
            end
        end
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_stopwatch_2dig.md
BCD_STOPWATCH_2DIG -- requirements
Module: bcd_stopwatch_2dig

Interface
REQ-001 Parameter DEB_DIV, 16000, clk cycles per debounce sample tick (1 kHz at 16 MHz).
REQ-002 Parameter TICK_DIV, 16000000, clk cycles per count tick (1 Hz at 16 MHz).
REQ-003 clk  input  1  system clock, 16 MHz, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_ss  input  1  raw start/stop pushbutton, asynchronous, active-high, bouncing.
REQ-006 btn_clr  input  1  raw clear pushbutton, asynchronous, active-high, bouncing.
REQ-007 dir  input  1  count direction: 0 = up, 1 = down; level-sampled, asynchronous.
REQ-008 d0  output  4  BCD units digit (0-9), registered; feeds display controller din0.
REQ-009 d1  output  4  BCD tens digit (0-9), registered; feeds display controller din1.
REQ-010 running  output  1  high while FSM is in RUN.
REQ-011 tc  output  1  one-cycle pulse on wrap (99->00 up, 00->99 down).

Function
REQ-012 btn_ss, btn_clr, dir each SHALL pass through a 2-flop synchronizer before use.
REQ-013 Debounce prescaler: 0..DEB_DIV-1 counter, deb_en high one cycle when count = DEB_DIV-1, then counter returns to 0.
REQ-014 Each button debounced state SHALL update only on deb_en and only when the current and previous deb_en samples agree.
REQ-015 Rising edge of a debounced button SHALL produce exactly one single-cycle pulse (ss_p, clr_p), delayed 1 cycle from the debounced-state change.
REQ-016 Tick prescaler: 0..TICK_DIV-1 counter, tick high one cycle at TICK_DIV-1; advances only in RUN, held at 0 in IDLE, held (frozen) in PAUSE.
REQ-017 FSM states IDLE, RUN, PAUSE.
REQ-018 IDLE: ss_p -> RUN; clr_p -> IDLE.
REQ-019 RUN: ss_p -> PAUSE; clr_p -> IDLE.
REQ-020 PAUSE: ss_p -> RUN, resuming the prescaler from its frozen value; clr_p -> IDLE.
REQ-021 clr_p SHALL set d1:d0 to 00, clear the tick prescaler, and force IDLE; clr_p wins over ss_p and tick in the same cycle.
REQ-022 On tick in RUN, up: d0 +1; d0 = 9 -> d0 = 0, d1 +1; 99 -> 00 with tc = 1 in the same cycle the digits update.
REQ-023 On tick in RUN, down: d0 -1; d0 = 0 -> d0 = 9, d1 -1; 00 -> 99 with tc = 1.
REQ-024 dir SHALL be sampled at the tick edge; changing dir mid-run affects only the next tick.
REQ-025 d0, d1 SHALL never hold values 10-15.
REQ-026 Simultaneous tick and ss_p in RUN: digits advance, then FSM enters PAUSE.
REQ-027 tc SHALL be 0 in every cycle without a wrap.

Reset
REQ-028 On rst: FSM = IDLE, d0 = d1 = 0, running = 0, tc = 0, both prescalers = 0, debounced states = 0, synchronizers = 0.
REQ-029 rst mid-count or mid-debounce SHALL abort the operation with no pulse emitted in the following cycle.
REQ-030 A button held through reset release SHALL NOT generate a pulse until it has been released and pressed again.

Verification (DEB_DIV = 4, TICK_DIV = 10)
REQ-031 Bench: press btn_ss with 5 bounce glitches shorter than 4 cycles, then hold -> exactly one ss_p, running = 1, digits step 00->01->02 every 10 cycles.
REQ-032 Bench: up count from 98, two ticks -> 99, then 00 with tc = 1 for one cycle; down count from 01, two ticks -> 00, then 99 with tc = 1.
REQ-033 Bench: RUN with prescaler at 6, press btn_ss -> PAUSE, digits frozen 50 cycles; press again -> next tick after 4 more RUN cycles.
REQ-034 Bench: btn_clr and btn_ss debounced edges in the same cycle at 37 -> d1:d0 = 00, IDLE, running = 0.
REQ-035 Bench: rst asserted at 45 during RUN with btn_ss held -> 00, IDLE after 1 cycle; no ss_p until btn_ss is released and re-pressed.
REQ-036 Bench: all runs -> assert d0 <= 9 and d1 <= 9 every cycle; tc high only in wrap cycles.
